// File: rtl/rv_plic_intr_coalesce_pkg.sv
// Shared types and default widths for the PLIC interrupt coalescing stage.
package rv_plic_intr_coalesce_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'b00,
      ACCUM = 2'b01,
      FIRE  = 2'b10
   } coal_state_e;

   localparam int unsigned DefNumSrc     = 32;
   localparam int unsigned DefCntWidth   = 8;
   localparam int unsigned DefTimerWidth = 16;

endpackage

// File: rtl/rv_plic_coalesce_src.sv
// One source of the coalescer: IDLE/ACCUM/FIRE FSM, saturating event counter,
// coalescing timer and sticky overflow flag. All outputs come straight from flops.
module rv_plic_coalesce_src
   import rv_plic_intr_coalesce_pkg::*;
#(
   parameter int unsigned CntWidth   = DefCntWidth,
   parameter int unsigned TimerWidth = DefTimerWidth
) (
   input  logic                  clk_i,
   input  logic                  rst_i,
   input  logic                  en_i,
   input  logic                  event_i,
   input  logic                  ack_i,
   input  logic [CntWidth-1:0]   thr_i,
   input  logic [TimerWidth-1:0] timeout_i,
   output logic                  intr_o,
   output logic                  overflow_o,
   output coal_state_e           state_o,
   output logic [CntWidth-1:0]   cnt_o
);

   localparam logic [CntWidth-1:0]   CntMax   = '1;
   localparam logic [TimerWidth-1:0] TimerMax = '1;

   coal_state_e           state_q, state_d;
   logic [CntWidth-1:0]   cnt_q, cnt_d;
   logic [TimerWidth-1:0] timer_q, timer_d;
   logic                  ovf_q, ovf_d;
   logic                  intr_q, intr_d;

   logic [CntWidth-1:0]   cnt_nx;
   logic [TimerWidth-1:0] timer_inc;
   logic                  timeout_hit;

   always_comb begin
      cnt_nx      = (cnt_q == CntMax) ? CntMax : cnt_q + CntWidth'(event_i);
      timer_inc   = (timer_q == TimerMax) ? TimerMax : timer_q + TimerWidth'(1);
      timeout_hit = (timeout_i != '0) && (timer_q == timeout_i - TimerWidth'(1));

      state_d = state_q;
      cnt_d   = cnt_q;
      timer_d = timer_q;
      ovf_d   = ovf_q;

      // Ack clears overflow in every state; a same-cycle saturated event re-sets it.
      if (ack_i) begin
         ovf_d = 1'b0;
      end

      if (!en_i) begin
         state_d = IDLE;
         cnt_d   = '0;
         timer_d = '0;
      end else begin
         if (event_i && (cnt_q == CntMax)) begin
            ovf_d = 1'b1;
         end

         unique case (state_q)
            IDLE: begin
               if (event_i) begin
                  timer_d = '0;
                  if (thr_i == CntWidth'(1)) begin
                     state_d = FIRE;
                     cnt_d   = '0;
                  end else begin
                     state_d = ACCUM;
                     cnt_d   = CntWidth'(1);
                  end
               end
            end
            ACCUM: begin
               cnt_d   = cnt_nx;
               timer_d = timer_inc;
               if ((cnt_nx >= thr_i) || timeout_hit) begin
                  state_d = FIRE;
                  cnt_d   = '0;
                  timer_d = '0;
               end
            end
            FIRE: begin
               // Events arriving while the request is pending open the next window.
               cnt_d   = cnt_nx;
               timer_d = '0;
               if (ack_i) begin
                  state_d = (cnt_nx != '0) ? ACCUM : IDLE;
               end
            end
            default: begin
               state_d = IDLE;
               cnt_d   = '0;
               timer_d = '0;
            end
         endcase
      end

      intr_d = (state_d == FIRE);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         cnt_q   <= '0;
         timer_q <= '0;
         ovf_q   <= 1'b0;
         intr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         timer_q <= timer_d;
         ovf_q   <= ovf_d;
         intr_q  <= intr_d;
      end
   end

   assign intr_o     = intr_q;
   assign overflow_o = ovf_q;
   assign state_o    = state_q;
   assign cnt_o      = cnt_q;

endmodule

// File: rtl/rv_plic_intr_coalesce.sv
// Interrupt moderation in front of rv_plic intr_src_i: one coalescing slice per
// source 1..NumSrc-1; source 0 is the PLIC's reserved "no interrupt" id and stays low.
module rv_plic_intr_coalesce
   import rv_plic_intr_coalesce_pkg::*;
#(
   parameter int unsigned NumSrc     = DefNumSrc,
   parameter int unsigned CntWidth   = DefCntWidth,
   parameter int unsigned TimerWidth = DefTimerWidth
) (
   input  logic                             clk_i,
   input  logic                             rst_i,
   input  logic [NumSrc-1:0]                event_i,
   input  logic [NumSrc-1:0]                cfg_en_i,
   input  logic [CntWidth-1:0]              cfg_cnt_thresh_i,
   input  logic [TimerWidth-1:0]            cfg_timeout_i,
   input  logic [NumSrc-1:0]                ack_i,
   output logic [NumSrc-1:0]                intr_o,
   output logic [NumSrc-1:0]                overflow_o,
   output logic [NumSrc-1:0][1:0]           dbg_state_o,
   output logic [NumSrc-1:0][CntWidth-1:0]  dbg_cnt_o
);

   logic [CntWidth-1:0] thr_eff;
   logic                unused_src0;

   // A zero threshold behaves as one: every event raises a request.
   assign thr_eff = (cfg_cnt_thresh_i == '0) ? CntWidth'(1) : cfg_cnt_thresh_i;

   assign intr_o[0]      = 1'b0;
   assign overflow_o[0]  = 1'b0;
   assign dbg_state_o[0] = IDLE;
   assign dbg_cnt_o[0]   = '0;
   assign unused_src0    = ^{event_i[0], cfg_en_i[0], ack_i[0]};

   for (genvar i = 1; i < NumSrc; i++) begin : g_src
      coal_state_e src_state;

      rv_plic_coalesce_src #(
         .CntWidth   (CntWidth),
         .TimerWidth (TimerWidth)
      ) u_src (
         .clk_i      (clk_i),
         .rst_i      (rst_i),
         .en_i       (cfg_en_i[i]),
         .event_i    (event_i[i]),
         .ack_i      (ack_i[i]),
         .thr_i      (thr_eff),
         .timeout_i  (cfg_timeout_i),
         .intr_o     (intr_o[i]),
         .overflow_o (overflow_o[i]),
         .state_o    (src_state),
         .cnt_o      (dbg_cnt_o[i])
      );

      assign dbg_state_o[i] = src_state;
   end

endmodule

// File: tb/tb_rv_plic_intr_coalesce.sv
// Directed bench for rv_plic_intr_coalesce: a full-size instance and a narrow
// (2-bit counter) instance for saturation and overflow behaviour.
module tb_rv_plic_intr_coalesce;
   import rv_plic_intr_coalesce_pkg::*;

   localparam int W = 1;

   // ---------------- clock / reset ----------------
   logic clk = 1'b0;
   logic rst;
   always #5 clk = ~clk;

   // ---------------- main instance (32 src, 8-bit cnt) ----------------
   logic [31:0]       ev, en, ack, intr, ovf;
   logic [7:0]        thr;
   logic [15:0]       to;
   logic [31:0][1:0]  dbg_st;
   logic [31:0][7:0]  dbg_cnt;

   rv_plic_intr_coalesce #(.NumSrc(32), .CntWidth(8), .TimerWidth(16)) dut (
      .clk_i            (clk),
      .rst_i            (rst),
      .event_i          (ev),
      .cfg_en_i         (en),
      .cfg_cnt_thresh_i (thr),
      .cfg_timeout_i    (to),
      .ack_i            (ack),
      .intr_o           (intr),
      .overflow_o       (ovf),
      .dbg_state_o      (dbg_st),
      .dbg_cnt_o        (dbg_cnt)
   );

   // ---------------- narrow instance (4 src, 2-bit cnt) ----------------
   logic [3:0]       s_ev, s_en, s_ack, s_intr, s_ovf;
   logic [1:0]       s_thr;
   logic [3:0]       s_to;
   logic [3:0][1:0]  s_st;
   logic [3:0][1:0]  s_cnt;

   rv_plic_intr_coalesce #(.NumSrc(4), .CntWidth(2), .TimerWidth(4)) dut_s (
      .clk_i            (clk),
      .rst_i            (rst),
      .event_i          (s_ev),
      .cfg_en_i         (s_en),
      .cfg_cnt_thresh_i (s_thr),
      .cfg_timeout_i    (s_to),
      .ack_i            (s_ack),
      .intr_o           (s_intr),
      .overflow_o       (s_ovf),
      .dbg_state_o      (s_st),
      .dbg_cnt_o        (s_cnt)
   );

   // ---------------- scoreboard ----------------
   logic [W-1:0] exp_q[$];
   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // ---------------- driver ----------------
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1;
      ev = '0; en = '1; ack = '0; thr = 8'd4; to = 16'd0;
      s_ev = '0; s_en = '1; s_ack = '0; s_thr = 2'b11; s_to = 4'd0;
      step();
      step();
      rst = 1'b0;
      check("rst_intr", intr, 0);
      check("rst_ovf", ovf, 0);
      check("rst_state", dbg_st, 0);
      check("rst_cnt3", dbg_cnt[3], 0);
      check("rst_s_intr", s_intr, 0);
      step();

      // 1: threshold 4 on src3, hold until ack at cycle 8
      for (int i = 0; i < 4; i++) begin
         ev[3] = 1'b1;
         step();
         ev[3] = 1'b0;
         check("t1_intr", intr[3], (i == 3));
      end
      check("t1_state_fire", dbg_st[3], FIRE);
      check("t1_cnt_clr", dbg_cnt[3], 0);
      repeat (4) step();
      check("t1_hold", intr[3], 1);
      ack[3] = 1'b1;
      step();
      ack[3] = 1'b0;
      check("t1_ack_intr", intr[3], 0);
      check("t1_ack_idle", dbg_st[3], IDLE);

      // 2: timeout 10 after a single src5 event
      to = 16'd10;
      ev[5] = 1'b1;
      step();
      ev[5] = 1'b0;
      for (int c = 1; c <= 11; c++) exp_q.push_back(W'(c == 11));
      while (exp_q.size() > 0) begin
         logic [W-1:0] e;
         e = exp_q.pop_front();
         check("t2_timeout", intr[5], e);
         if (exp_q.size() > 0) step();
      end
      ack[5] = 1'b1;
      step();
      ack[5] = 1'b0;
      check("t2_ack_idle", dbg_st[5], IDLE);
      to = 16'd0;

      // 3: event + ack in the same cycle opens a new window (thr=2)
      thr = 8'd2;
      ev[2] = 1'b1;
      step();
      step();
      ev[2] = 1'b0;
      check("t3_fire", intr[2], 1);
      ev[2] = 1'b1;
      step();
      ack[2] = 1'b1;
      step();
      ev[2] = 1'b0;
      ack[2] = 1'b0;
      check("t3_ack_intr", intr[2], 0);
      check("t3_accum", dbg_st[2], ACCUM);
      check("t3_cnt2", dbg_cnt[2], 2);
      step();
      check("t3_refire", intr[2], 1);
      ack[2] = 1'b1;
      step();
      ack[2] = 1'b0;
      check("t3_idle", dbg_st[2], IDLE);

      // threshold 0 acts as 1
      thr = 8'd0;
      ev[6] = 1'b1;
      step();
      ev[6] = 1'b0;
      check("thr0_fire", intr[6], 1);
      ack[6] = 1'b1;
      step();
      ack[6] = 1'b0;
      check("thr0_idle", dbg_st[6], IDLE);

      // threshold lowered below current count fires without an event
      thr = 8'd8;
      ev[4] = 1'b1;
      repeat (3) step();
      ev[4] = 1'b0;
      check("low_cnt3", dbg_cnt[4], 3);
      step();
      check("low_nofire", intr[4], 0);
      thr = 8'd2;
      step();
      check("low_fire", intr[4], 1);
      ack[4] = 1'b1;
      step();
      ack[4] = 1'b0;
      check("low_idle", dbg_st[4], IDLE);
      thr = 8'd4;

      // 5: disable src7 while in FIRE
      ev[7] = 1'b1;
      repeat (4) step();
      ev[7] = 1'b0;
      check("t5_fire", intr[7], 1);
      en[7] = 1'b0;
      step();
      check("t5_dis_intr", intr[7], 0);
      check("t5_dis_idle", dbg_st[7], IDLE);
      ev[7] = 1'b1;
      repeat (2) step();
      ev[7] = 1'b0;
      check("t5_drop_cnt", dbg_cnt[7], 0);
      en[7] = 1'b1;
      repeat (3) step();
      check("t5_reen_intr", intr[7], 0);
      check("t5_reen_idle", dbg_st[7], IDLE);
      ev[7] = 1'b1;
      step();
      ev[7] = 1'b0;
      check("t5_restart", dbg_cnt[7], 1);
      check("t5_accum", dbg_st[7], ACCUM);

      // 4: narrow counter saturation and sticky overflow (thr = 3)
      for (int i = 0; i < 3; i++) begin
         s_ev[1] = 1'b1;
         step();
         s_ev[1] = 1'b0;
         check("t4_intr", s_intr[1], (i == 2));
      end
      for (int i = 0; i < 4; i++) begin
         s_ev[1] = 1'b1;
         step();
         s_ev[1] = 1'b0;
         check("t4_cnt", s_cnt[1], (i < 3) ? i + 1 : 3);
         check("t4_ovf", s_ovf[1], (i == 3));
      end
      s_ev[1] = 1'b1;
      s_ack[1] = 1'b1;
      step();
      s_ev[1] = 1'b0;
      s_ack[1] = 1'b0;
      check("t4_set_wins", s_ovf[1], 1);
      check("t4_accum", s_st[1], ACCUM);
      check("t4_cnt_sat", s_cnt[1], 3);
      check("t4_ack_intr", s_intr[1], 0);
      step();
      check("t4_refire", s_intr[1], 1);
      s_en[1] = 1'b0;
      step();
      check("t4_dis_intr", s_intr[1], 0);
      check("t4_dis_ovf", s_ovf[1], 1);
      s_en[1] = 1'b1;
      s_ack[1] = 1'b1;
      step();
      s_ack[1] = 1'b0;
      check("t4_ack_clr", s_ovf[1], 0);
      check("t4_ack_nointr", s_intr[1], 0);
      check("t4_ack_idle", s_st[1], IDLE);

      // 6: asynchronous reset with src7 in ACCUM and src6 in FIRE
      ev[6] = 1'b1;
      repeat (4) step();
      ev[6] = 1'b0;
      check("t6_pre_fire", intr[6], 1);
      check("t6_pre_accum", dbg_st[7], ACCUM);
      #3;
      rst = 1'b1;
      #1;
      check("t6_async_intr", intr, 0);
      check("t6_async_ovf", ovf, 0);
      check("t6_async_state", dbg_st, 0);
      check("t6_async_cnt7", dbg_cnt[7], 0);
      @(posedge clk);
      #1;
      rst = 1'b0;
      ev[7] = 1'b1;
      ev[0] = 1'b1;
      step();
      ev = '0;
      check("t6_restart_cnt", dbg_cnt[7], 1);
      check("t6_restart_st", dbg_st[7], ACCUM);
      thr = 8'd0;
      for (int i = 0; i < 3; i++) begin
         ev[0] = 1'b1;
         ev[1] = 1'b1;
         step();
         ev = '0;
         check("t6_src0_intr", intr[0], 0);
         check("t6_src0_ovf", ovf[0], 0);
         check("t6_src1_intr", intr[1], 1);
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
